if_id_pipe_stage: RTL and testbench
===================================

Name: if_id_pipe_stage

Overview:
- Parametrised IF/ID pipeline register for the pipelined CPU.
- Carries PC plus instruction from fetch to decode using a valid/ready handshake on both sides.
- A 2-entry skid buffer sustains 1 beat/cycle under back-pressure.
- A synchronous flush drops in-flight beats on branch/jump and injects a NOP bubble.

Parameters:
- PC_W, 32, PC payload width in bits.
- INST_W, 32, instruction payload width in bits.
- NOP_INST, 32'h0000_0000, instruction value presented while the stage holds no valid beat (width INST_W).

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- flush_i  in  1  synchronous flush request from branch resolution.
- in_valid_i  in  1  fetch beat valid.
- in_ready_o  out  1  stage can accept a beat this cycle.
- in_pc_i  in  PC_W  fetch PC.
- in_inst_i  in  INST_W  fetched instruction.
- out_valid_o  out  1  decode beat valid.
- out_ready_i  in  1  decode consumes beat this cycle.
- out_pc_o  out  PC_W  PC to decode.
- out_inst_o  out  INST_W  instruction to decode.

Behaviour:
- Storage is a main register (drives out_*) and a skid register, each with its own valid bit.
- in_ready_o = !skid_valid. It is registered-state derived only, with no combinational path from out_ready_i.
- Handshake rules:
  - Accept = in_valid_i & in_ready_o.
  - Transfer out = out_valid_o & out_ready_i.
  - Payload on in_* is sampled only on accept.
- Reset (rst_i=0 at a rising edge):
  - main_valid=0, skid_valid=0.
  - out_valid_o=0, out_pc_o=0, out_inst_o=NOP_INST, in_ready_o=1 after the edge.
  - Inputs are ignored while reset is sampled low.
  - Reset mid-stall discards both entries.
- States: EMPTY (main invalid, skid invalid), BUSY (main valid, skid invalid), FULL (both valid).
- EMPTY:
  - accept -> BUSY; beat loads main; out_valid_o=1 the next cycle (latency 1).
  - otherwise stay.
- BUSY:
  - accept & transfer -> BUSY; new beat loads main.
  - accept & !transfer -> FULL; new beat loads skid.
  - !accept & transfer -> EMPTY; out_inst_o <= NOP_INST and out_pc_o holds.
  - otherwise hold.
- FULL:
  - in_ready_o=0, so no accept.
  - transfer -> BUSY; skid moves to main.
  - otherwise hold. Main and skid payloads stay stable while out_ready_i=0.
- Ordering: beats leave in acceptance order. No beat is duplicated or dropped except by flush.
- Flush:
  - Highest priority below reset. The next state is EMPTY regardless of current state.
  - Main and skid are invalidated; out_inst_o <= NOP_INST.
  - A beat offered on in_* in the flush cycle is discarded even if in_ready_o=1.
  - A transfer occurring in the flush cycle is still consumed by decode (it was valid that cycle).
  - in_ready_o=1 the cycle after flush.
- Invariant: out_valid_o=0 implies out_inst_o==NOP_INST.
- No arithmetic on the payload; widths pass through unchanged.

Optional Feature:
- Macro: IF_ID_PIPE_STAGE_PERF_EN.
- When defined:
  - Adds output ports stall_cnt_o [15:0] and flush_drop_cnt_o [15:0].
  - stall_cnt_o increments each cycle with out_valid_o=1 & out_ready_i=0.
  - flush_drop_cnt_o increments on each flush cycle where main_valid|skid_valid=1, counting one per flush event, not per beat.
  - Both counters saturate at 16'hFFFF and reset to 0 on rst_i=0.
  - Flush does not clear the counters.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset check: hold rst_i=0 for 2 cycles with in_valid_i=1 -> out_valid_o=0, out_inst_o=NOP_INST, out_pc_o=0; in_ready_o=1 after release.
- Streaming: out_ready_i=1; feed PC 0x00,0x04,0x08 with inst 0xA,0xB,0xC on back-to-back cycles -> out_valid_o high from cycle 1, outputs appear in order one cycle later, in_ready_o never drops.
- Back-pressure: feed 0x10/0x20 and 0x14/0x24, then drop out_ready_i for 3 cycles -> in_ready_o=0 after 2 accepts and out_pc_o holds 0x10. Raise out_ready_i -> 0x10 then 0x14 delivered, no loss or duplication.
- Flush in FULL: state FULL (0x30,0x34 held), assert flush_i with in_valid_i=1 PC 0x38 -> next cycle out_valid_o=0, out_inst_o=NOP_INST, in_ready_o=1; 0x38 never appears at the output.
- Flush concurrent with transfer in BUSY: out_ready_i=1, flush_i=1 -> held beat counted as transferred, stage EMPTY next cycle.
- With IF_ID_PIPE_STAGE_PERF_EN: 5 stall cycles then one flush holding data -> stall_cnt_o=5, flush_drop_cnt_o=1. Force 70000 stall cycles -> stall_cnt_o=16'hFFFF.

Source files
------------

// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline register with a 2-entry skid buffer; optional perf counters under IF_ID_PIPE_STAGE_PERF_EN.
// Latency: 1 cycle from accept to out_valid_o; sustains 1 beat/cycle.
// Backpressure: in_ready_o drops only when the skid entry is occupied (pure register decode, no path from out_ready_i).
module if_id_pipe_stage #(
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PC_W-1:0]   in_pc_i,
  input  logic [INST_W-1:0] in_inst_i,
`ifdef IF_ID_PIPE_STAGE_PERF_EN
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       flush_drop_cnt_o,
`endif
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   out_pc_o,
  output logic [INST_W-1:0] out_inst_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   main_pc;
  logic [INST_W-1:0] main_inst;
  logic [PC_W-1:0]   skid_pc;
  logic [INST_W-1:0] skid_inst;

  logic main_valid;
  logic skid_valid;
  logic accept;
  logic transfer;

  assign main_valid  = (state == BUSY) || (state == FULL);
  assign skid_valid  = (state == FULL);
  assign in_ready_o  = !skid_valid;
  assign out_valid_o = main_valid;
  assign out_pc_o    = main_pc;
  assign out_inst_o  = main_inst;
  assign accept      = in_valid_i && in_ready_o;
  assign transfer    = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= EMPTY;
      main_pc   <= '0;
      main_inst <= NOP_INST;
      skid_pc   <= '0;
      skid_inst <= NOP_INST;
    end else if (flush_i) begin
      // A beat leaving in this cycle is still consumed by decode; everything else is dropped.
      state     <= EMPTY;
      main_inst <= NOP_INST;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_pc   <= in_pc_i;
            main_inst <= in_inst_i;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (accept && transfer) begin
            main_pc   <= in_pc_i;
            main_inst <= in_inst_i;
          end else if (accept) begin
            skid_pc   <= in_pc_i;
            skid_inst <= in_inst_i;
            state     <= FULL;
          end else if (transfer) begin
            // PC is left as-is so the idle output only differs in the instruction field.
            main_inst <= NOP_INST;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (transfer) begin
            main_pc   <= skid_pc;
            main_inst <= skid_inst;
            state     <= BUSY;
          end
        end
        default: begin
          main_inst <= NOP_INST;
          state     <= EMPTY;
        end
      endcase
    end
  end

`ifdef IF_ID_PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_drop_cnt_q;

  assign stall_cnt_o      = stall_cnt_q;
  assign flush_drop_cnt_o = flush_drop_cnt_q;

  // Both counters saturate and survive flush; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_q      <= '0;
      flush_drop_cnt_q <= '0;
    end else begin
      if (out_valid_o && !out_ready_i && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (flush_i && (main_valid || skid_valid) && (flush_drop_cnt_q != 16'hFFFF)) begin
        flush_drop_cnt_q <= flush_drop_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Scoreboard bench for if_id_pipe_stage: a queue of accepted beats models the stage contents.
module tb_if_id_pipe_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } beat_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_pc_i = '0;
  logic [31:0] in_inst_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_pc_o;
  logic [31:0] out_inst_o;
`ifdef IF_ID_PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_drop_cnt_o;
`endif

  if_id_pipe_stage #(
    .PC_W    (32),
    .INST_W  (32),
    .NOP_INST(NOP)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_pc_i    (in_pc_i),
    .in_inst_i  (in_inst_i),
`ifdef IF_ID_PIPE_STAGE_PERF_EN
    .stall_cnt_o     (stall_cnt_o),
    .flush_drop_cnt_o(flush_drop_cnt_o),
`endif
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_pc_o   (out_pc_o),
    .out_inst_o (out_inst_o)
  );

  always #5 clk_i = ~clk_i;

  beat_t       exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        chk_en = 1'b0;
  logic [31:0] last_pc = '0;
  int          stall_m = 0;
  int          fdrop_m = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle at the falling edge; the model updates after the monitor has popped.
  task automatic cycle(input logic r, input logic v, input logic [31:0] pc,
                       input logic [31:0] inst, input logic rdy, input logic fl);
    logic acc;
    logic stall;
    logic fdrop;
    @(negedge clk_i);
    rst_i       = r;
    in_valid_i  = v;
    in_pc_i     = pc;
    in_inst_i   = inst;
    out_ready_i = rdy;
    flush_i     = fl;
    acc   = r && !fl && v && (exp_q.size() < 2);
    stall = r && (exp_q.size() > 0) && !rdy;
    fdrop = r && fl && (exp_q.size() > 0);
    #3;
    if (!r) begin
      exp_q.delete();
      last_pc = '0;
      stall_m = 0;
      fdrop_m = 0;
      chk_en  = 1'b1;
    end else begin
      if (fl) exp_q.delete();
      else if (acc) exp_q.push_back('{pc: pc, inst: inst});
      if (stall && stall_m < 16'hFFFF) stall_m++;
      if (fdrop && fdrop_m < 16'hFFFF) fdrop_m++;
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, 32'h0, rdy, 1'b0);
  endtask

  // Monitor: compares what the DUT presents against the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (chk_en) begin
        chk("out_valid", {63'd0, out_valid_o}, {63'd0, exp_q.size() > 0});
        chk("in_ready", {63'd0, in_ready_o}, {63'd0, exp_q.size() < 2});
        if (out_valid_o !== 1'b1) begin
          chk("idle_inst_nop", {32'd0, out_inst_o}, {32'd0, NOP});
          chk("idle_pc_hold", {32'd0, out_pc_o}, {32'd0, last_pc});
        end else if (exp_q.size() == 0) begin
          chk("spurious_beat", {32'd0, out_pc_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          last_pc = exp_q[0].pc;
          chk("beat_pc", {32'd0, out_pc_o}, {32'd0, exp_q[0].pc});
          chk("beat_inst", {32'd0, out_inst_o}, {32'd0, exp_q[0].inst});
          if (out_ready_i && rst_i) void'(exp_q.pop_front());
        end
`ifdef IF_ID_PIPE_STAGE_PERF_EN
        chk("stall_cnt", {48'd0, stall_cnt_o}, stall_m[63:0]);
        chk("flush_drop_cnt", {48'd0, flush_drop_cnt_o}, fdrop_m[63:0]);
`endif
      end
    end
  end

  initial begin
    // Reset held for two cycles while a beat is offered.
    cycle(1'b0, 1'b1, 32'h100, 32'hDEAD, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'h104, 32'hBEEF, 1'b1, 1'b0);
    idle(1, 1'b1);

    // Streaming back-to-back.
    cycle(1'b1, 1'b1, 32'h00, 32'hA, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'h04, 32'hB, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'h08, 32'hC, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Back-pressure: two accepts fill the stage, a third offer is refused.
    cycle(1'b1, 1'b1, 32'h10, 32'h20, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h14, 32'h24, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h18, 32'h28, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Flush while FULL with a beat offered.
    cycle(1'b1, 1'b1, 32'h30, 32'h130, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h34, 32'h134, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h38, 32'h138, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Flush concurrent with a transfer in BUSY.
    cycle(1'b1, 1'b1, 32'h40, 32'h140, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h44, 32'h144, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Reset in the middle of a stall.
    cycle(1'b1, 1'b1, 32'h50, 32'h150, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h54, 32'h154, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h58, 32'h158, 1'b0, 1'b0);
    idle(2, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
            $urandom, $urandom, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 15) == 0));
    end
    idle(3, 1'b1);

`ifdef IF_ID_PIPE_STAGE_PERF_EN
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h60, 32'h160, 1'b0, 1'b0);
    idle(5, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    @(negedge clk_i);
    #2;
    chk("perf_stall_5", {48'd0, stall_cnt_o}, 64'd5);
    chk("perf_flush_1", {48'd0, flush_drop_cnt_o}, 64'd1);
    cycle(1'b1, 1'b1, 32'h64, 32'h164, 1'b0, 1'b0);
    idle(70000, 1'b0);
    @(negedge clk_i);
    #2;
    chk("perf_stall_sat", {48'd0, stall_cnt_o}, 64'hFFFF);
    idle(2, 1'b1);
`endif

    @(negedge clk_i);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
